// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock on ser_d with ser_en high, optionally followed by
// a forced idle gap. Between words ser_en and ser_d are both held low.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CntW      = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx   = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] PenultIdx = CntW'(WIDTH - 2);
    localparam logic [7:0]      GapLast   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam bit              HasGap    = (GAP_CYCLES > 0);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic             in_ready_q, in_ready_d;
    logic             ser_d_q, ser_d_d;
    logic             ser_en_q, ser_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Bit that leaves next, given the current contents of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the head bit so the following one moves into the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Next-state and next-output decode; every output is taken from a flop.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        in_ready_d = in_ready_q;
        ser_d_d    = ser_d_q;
        ser_en_d   = ser_en_q;
        busy_d     = busy_q;
        done_d     = done_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    // First bit goes out in the cycle right after acceptance.
                    state_d    = StShift;
                    sreg_d     = advance(in_data);
                    ser_d_d    = head_bit(in_data);
                    ser_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    done_d     = 1'b0;
                    cnt_d      = '0;
                end
            end
            StShift: begin
                if (cnt_q == LastIdx) begin
                    ser_en_d = 1'b0;
                    ser_d_d  = 1'b0;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    sreg_d   = '0;
                    if (HasGap) begin
                        state_d = StGap;
                        gap_d   = 8'd0;
                    end else begin
                        state_d    = StIdle;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    ser_d_d = head_bit(sreg_q);
                    sreg_d  = advance(sreg_q);
                    // cnt_q is the index currently on the wire; the next one is last.
                    done_d  = (cnt_q == PenultIdx);
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d    = StIdle;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                    gap_d      = 8'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                sreg_d     = '0;
                cnt_d      = '0;
                gap_d      = 8'd0;
                in_ready_d = 1'b1;
                ser_d_d    = 1'b0;
                ser_en_d   = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            cnt_q      <= '0;
            gap_q      <= 8'd0;
            in_ready_q <= 1'b1;
            ser_d_q    <= 1'b0;
            ser_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            in_ready_q <= in_ready_d;
            ser_d_q    <= ser_d_d;
            ser_en_q   <= ser_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ser_d    = ser_d_q;
    assign ser_en   = ser_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer. Three instances cover MSB-first,
// LSB-first and MSB-first with a 3-cycle gap. Stimulus pushes expected
// {done, bit} pairs; a negedge monitor pops one per ser_en cycle.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       rdy   [3];
    logic       sd    [3];
    logic       se    [3];
    logic       bsy   [3];
    logic       dn    [3];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(data[0]), .in_valid(valid[0]),
        .in_ready(rdy[0]), .ser_d(sd[0]), .ser_en(se[0]), .busy(bsy[0]), .done(dn[0])
    );
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(data[1]), .in_valid(valid[1]),
        .in_ready(rdy[1]), .ser_d(sd[1]), .ser_en(se[1]), .busy(bsy[1]), .done(dn[1])
    );
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(data[2]), .in_valid(valid[2]),
        .in_ready(rdy[2]), .ser_d(sd[2]), .ser_en(se[2]), .busy(bsy[2]), .done(dn[2])
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    bit         mon_on = 1'b0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [1:0] e);
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Called at posedge+1. Waits for in_ready, lets the next edge accept,
    // returns at acceptance edge +1 with the cycle stamp of that edge.
    task automatic send(input int idx, input logic [7:0] w, input bit msb, input bit hold,
                        output int acc);
        int t;
        t          = 0;
        acc        = -1;
        data[idx]  = w;
        valid[idx] = 1'b1;
        while (rdy[idx] !== 1'b1 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL ready_timeout[%0d]: got in_ready=0 for 200 cycles expected 1", idx);
            valid[idx] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            for (int k = 0; k < 8; k++) begin
                logic b;
                b = msb ? w[7-k] : w[k];
                push_exp(idx, {(k == 7), b});
            end
            if (!hold) valid[idx] = 1'b0;
        end
    endtask

    // Monitor: quiet/busy invariants every cycle, stream pops while ser_en=1.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                logic [1:0] e;
                bit         have;
                have = 1'b0;
                e    = 2'b00;
                checks++;
                if (bsy[i] !== ~rdy[i]) begin
                    errors++;
                    $display("FAIL busy_vs_ready[%0d]: got busy=%b in_ready=%b expected opposite",
                             i, bsy[i], rdy[i]);
                end
                if (se[i] !== 1'b1) begin
                    checks++;
                    if ({se[i], sd[i], dn[i]} !== 3'b000) begin
                        errors++;
                        $display("FAIL quiet[%0d]: got en,d,done=%b%b%b expected 000",
                                 i, se[i], sd[i], dn[i]);
                    end
                end else begin
                    case (i)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    endcase
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL unexpected_bit[%0d]: got ser_en=1 expected no word", i);
                    end else if ({dn[i], sd[i]} !== e) begin
                        errors++;
                        $display("FAIL stream[%0d]: got done,d=%b%b expected %b%b",
                                 i, dn[i], sd[i], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        int a1;
        int a2;
        int dummy;

        // Reset held with in_valid high: nothing may be captured.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data[i]  = 8'hA5;
            valid[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), {31'd0, rdy[i]}, 32'd1);
            check($sformatf("rst_ser_en[%0d]", i), {31'd0, se[i]}, 32'd0);
            check($sformatf("rst_ser_d[%0d]", i), {31'd0, sd[i]}, 32'd0);
            check($sformatf("rst_busy[%0d]", i), {31'd0, bsy[i]}, 32'd0);
            check($sformatf("rst_done[%0d]", i), {31'd0, dn[i]}, 32'd0);
        end
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // MSB-first A5; idle again in the ninth cycle after acceptance.
        send(0, 8'hA5, 1'b1, 1'b0, dummy);
        repeat (8) @(posedge clk);
        #1;
        check("a5_ready_after", {31'd0, rdy[0]}, 32'd1);
        check("a5_en_after", {31'd0, se[0]}, 32'd0);

        // LSB-first 01.
        send(1, 8'h01, 1'b0, 1'b0, dummy);
        repeat (10) @(posedge clk);
        #1;

        // Gap of 3 with in_valid held: FF then 00, accepted 12 cycles apart.
        send(2, 8'hFF, 1'b1, 1'b1, a1);
        #0;
        check("gap_ready_low", {31'd0, rdy[2]}, 32'd0);
        send(2, 8'h00, 1'b1, 1'b0, a2);
        check("gap_spacing", a2 - a1, 32'd12);
        repeat (14) @(posedge clk);
        #1;

        // Input changed after acceptance must not affect the word.
        send(0, 8'hF0, 1'b1, 1'b0, dummy);
        @(posedge clk);
        #1;
        data[0] = 8'h00;
        repeat (10) @(posedge clk);
        #1;

        // Reset sampled at the edge after bit index 3 of C3 is on the wire.
        send(0, 8'hC3, 1'b1, 1'b0, dummy);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ser_en", {31'd0, se[0]}, 32'd0);
        check("midrst_ser_d", {31'd0, sd[0]}, 32'd0);
        check("midrst_in_ready", {31'd0, rdy[0]}, 32'd1);
        check("midrst_done", {31'd0, dn[0]}, 32'd0);
        check("midrst_bits_left", qsize(0), 32'd4);
        q0.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h5A, 1'b1, 1'b0, dummy);
        repeat (12) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) check($sformatf("drained[%0d]", i), qsize(i), 32'd0);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
